// File: rtl/prio_arbiter_pkg.sv
// Shared types and helpers for the N-requester priority arbiter.
//   arb_state_t : FSM state (IDLE, GRANT)
//   arb_mode_t  : arbitration mode (FIXED = 0, RR = 1)
//   onehot(idx) : one-hot vector of width MAX_N with bit idx set
package prio_arbiter_pkg;

    localparam int unsigned MAX_N = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef enum logic {
        FIXED = 1'b0,
        RR    = 1'b1
    } arb_mode_t;

    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        return {{(MAX_N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/prio_arbiter_if.sv
// Request/grant bundle between the requesting agents and the arbiter.
//   req     : level request per agent            (master -> slave)
//   mode    : 0 = fixed priority, 1 = round-robin (master -> slave)
//   gnt     : registered one-hot grant            (slave -> master)
//   gnt_idx : binary index of the granted agent   (slave -> master)
//   gnt_vld : a grant is active                   (slave -> master)
interface prio_arbiter_if #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
);
    logic [N-1:0]  req;
    logic          mode;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_vld;

    modport master (output req, mode, input gnt, gnt_idx, gnt_vld);
    modport slave  (input req, mode, output gnt, gnt_idx, gnt_vld);
endinterface

// File: rtl/prio_enc_n.sv
// Parametrised combinational priority encoder; the highest set index wins.
//   in  : candidate vector
//   idx : index of the highest set bit (0 when none)
//   vld : at least one bit of in is set
module prio_enc_n #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  in,
    output logic [IW-1:0] idx,
    output logic          vld
);
    // Ascending scan: the last set bit seen overwrites earlier ones.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (in[i]) begin
                idx = IW'(i);
                vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/prio_arbiter.sv
// N-requester arbiter with registered grant, fixed-priority and
// round-robin modes, and a bounded hold time in round-robin mode.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/grant bundle (slave side): req, mode in;
//           gnt, gnt_idx, gnt_vld out (all registered)
module prio_arbiter
    import prio_arbiter_pkg::*;
#(
    parameter int N        = 8,
    parameter int IW       = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    prio_arbiter_if.slave bus
);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t    state;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] idx_q;
    logic          vld_q;
    logic [7:0]    hold_cnt;
    logic [IW-1:0] ptr;

    logic          mode_rr;
    logic          holder_req;
    logic          expire;
    logic          take;
    logic [N-1:0]  holder_mask;
    logic [N-1:0]  cand;
    logic [N-1:0]  below;
    logic [IW-1:0] all_idx;
    logic [IW-1:0] low_idx;
    logic [IW-1:0] win_idx;
    logic          all_vld;
    logic          low_vld;

    assign mode_rr    = (arb_mode_t'(bus.mode) == RR);
    assign holder_req = bus.req[idx_q];
    assign expire     = mode_rr && (hold_cnt == HOLD_LAST);

    // Masking the holder is only needed at expiry; on release the holder
    // is not requesting, so the same candidate vector serves every case.
    assign holder_mask = (state == GRANT) ? N'(onehot(32'(idx_q))) : '0;
    assign cand        = bus.req & ~holder_mask;
    assign below       = cand & ((N'(1) << ptr) - N'(1));

    prio_enc_n #(.N(N), .IW(IW)) u_enc_all (
        .in  (cand),
        .idx (all_idx),
        .vld (all_vld)
    );

    prio_enc_n #(.N(N), .IW(IW)) u_enc_low (
        .in  (below),
        .idx (low_idx),
        .vld (low_vld)
    );

    // Round-robin: search below the pointer first, then wrap to the top.
    assign win_idx = (mode_rr && low_vld) ? low_idx : all_idx;
    assign take    = all_vld && ((state == IDLE) || !holder_req || expire);

    // A new grant is taken ahead of the per-state handling, since IDLE,
    // release and expiry all load the grant identically.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            vld_q    <= 1'b0;
            hold_cnt <= '0;
            ptr      <= IW'(N - 1);
        end else if (take) begin
            state    <= GRANT;
            gnt_q    <= N'(onehot(32'(win_idx)));
            idx_q    <= win_idx;
            vld_q    <= 1'b1;
            hold_cnt <= '0;
            ptr      <= win_idx;
        end else begin
            case (state)
                IDLE: ;
                GRANT: begin
                    if (!holder_req) begin
                        state <= IDLE;
                        gnt_q <= '0;
                        idx_q <= '0;
                        vld_q <= 1'b0;
                    end else if (expire) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = vld_q;

endmodule
